// File: rtl/rd_fifo_fill_ctrl.sv
// rd_fifo_fill_ctrl: write-clock-domain scheduler that splits a frame read into memory
// bursts, issues a burst only when rd_fifo has room for it, and forwards returned beats.
module rd_fifo_fill_ctrl #(
  parameter int unsigned ADDR_WIDTH       = 28,
  parameter int unsigned DATA_WIDTH       = 256,
  parameter int unsigned FIFO_DEPTH_WIDTH = 7,
  parameter int unsigned BURST_LEN        = 16,
  parameter int unsigned MARGIN           = 2
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst,
  input  logic                      frame_start,
  input  logic [ADDR_WIDTH-1:0]     frame_base_addr,
  input  logic [23:0]               frame_beats,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      rd_cmd_valid,
  input  logic                      rd_cmd_ready,
  output logic [ADDR_WIDTH-1:0]     rd_cmd_addr,
  output logic [7:0]                rd_cmd_len,
  input  logic                      rd_data_valid,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      fifo_wr_en,
  output logic [DATA_WIDTH-1:0]     fifo_wr_data,
  input  logic                      fifo_wr_full,
  input  logic [FIFO_DEPTH_WIDTH:0] fifo_water_level,
  output logic                      err
);

  localparam int unsigned FRAME_W    = 24;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned BL_W       = LEN_W + 1;
  localparam int unsigned CNT_W      = FIFO_DEPTH_WIDTH + 1;
  localparam int unsigned SUM_W      = FIFO_DEPTH_WIDTH + 3;
  localparam int unsigned CAPACITY   = 1 << FIFO_DEPTH_WIDTH;
  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, CHECK, REQ, DRAIN} state_t;

  state_t                 state_q;
  logic                   busy_q;
  logic                   frame_done_q;
  logic                   rd_cmd_valid_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_W-1:0]       rd_cmd_len_q;
  logic [FRAME_W-1:0]     remaining_q;
  logic [CNT_W-1:0]       outstanding_q;
  logic                   fifo_wr_en_q;
  logic [DATA_WIDTH-1:0]  fifo_wr_data_q;
  logic                   err_q;

  logic [BL_W-1:0]        burst_d;
  logic [BL_W-1:0]        cmd_beats;
  logic [SUM_W-1:0]       need_d;
  logic                   room;
  logic                   accept;
  logic                   beat_ok;
  logic                   start_clr;
  logic [FRAME_W-1:0]     remaining_d;
  logic [CNT_W-1:0]       outstanding_d;

  // Burst sizing, room check, beat acceptance and in-flight beat accounting.
  always_comb begin
    burst_d     = (remaining_q < FRAME_W'(BURST_LEN)) ? BL_W'(remaining_q) : BL_W'(BURST_LEN);
    cmd_beats   = BL_W'(rd_cmd_len_q) + BL_W'(1);
    need_d      = SUM_W'(fifo_water_level) + SUM_W'(outstanding_q) + SUM_W'(burst_d)
                + SUM_W'(MARGIN);
    room        = (need_d <= SUM_W'(CAPACITY));
    accept      = rd_cmd_valid_q & rd_cmd_ready;
    remaining_d = remaining_q - FRAME_W'(cmd_beats);
    // A beat already in the write register has not been subtracted yet.
    beat_ok     = rd_data_valid & (outstanding_q > CNT_W'(fifo_wr_en_q));
    start_clr   = frame_start & (state_q == IDLE);
    outstanding_d = outstanding_q;
    if (accept) begin
      outstanding_d = outstanding_d + CNT_W'(cmd_beats);
    end
    if (fifo_wr_en_q) begin
      outstanding_d = outstanding_d - CNT_W'(1);
    end
  end

  // Frame FSM: latch frame, size and gate each burst, hold the command until accepted, drain.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      rd_cmd_valid_q <= 1'b0;
      addr_q         <= '0;
      rd_cmd_len_q   <= '0;
      remaining_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            if (frame_beats != '0) begin
              addr_q      <= frame_base_addr;
              remaining_q <= frame_beats;
              busy_q      <= 1'b1;
              state_q     <= CHECK;
            end else begin
              frame_done_q <= 1'b1;
            end
          end
        end
        CHECK: begin
          rd_cmd_len_q <= LEN_W'(burst_d - BL_W'(1));
          if (room) begin
            rd_cmd_valid_q <= 1'b1;
            state_q        <= REQ;
          end
        end
        REQ: begin
          if (accept) begin
            rd_cmd_valid_q <= 1'b0;
            addr_q         <= addr_q + ADDR_WIDTH'(cmd_beats) * ADDR_WIDTH'(BEAT_BYTES);
            remaining_q    <= remaining_d;
            state_q        <= (remaining_d != '0) ? CHECK : DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding_q == '0) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Returned-beat path into rd_fifo with one cycle of latency, plus in-flight count.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
      outstanding_q  <= '0;
    end else begin
      fifo_wr_en_q  <= beat_ok;
      outstanding_q <= outstanding_d;
      if (beat_ok) begin
        fifo_wr_data_q <= rd_data;
      end
    end
  end

  // Sticky error: unexpected beat or write into a full FIFO; cleared by an accepted start.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (err_q & ~start_clr) | (rd_data_valid & ~beat_ok) | (fifo_wr_en_q & fifo_wr_full);
    end
  end

  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign rd_cmd_valid = rd_cmd_valid_q;
  assign rd_cmd_addr  = addr_q;
  assign rd_cmd_len   = rd_cmd_len_q;
  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign err          = err_q;

endmodule

// File: tb/tb_rd_fifo_fill_ctrl.sv
// Bench for rd_fifo_fill_ctrl: a memory responder and an rd_fifo occupancy model drive the
// DUT; issued commands, FIFO writes and frame completion are compared with a frame planner.
`timescale 1ns/1ps
module tb_rd_fifo_fill_ctrl;

  localparam int unsigned AW  = 28;
  localparam int unsigned DW  = 256;
  localparam int unsigned CAP = 128;
  localparam int unsigned BL  = 16;
  localparam int unsigned LAT = 4;

  logic          wr_clk;
  logic          wr_rst;
  logic          frame_start;
  logic [AW-1:0] frame_base_addr;
  logic [23:0]   frame_beats;
  logic          busy;
  logic          frame_done;
  logic          rd_cmd_valid;
  logic          rd_cmd_ready;
  logic [AW-1:0] rd_cmd_addr;
  logic [7:0]    rd_cmd_len;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_wr_full;
  logic [7:0]    fifo_water_level;
  logic          err;

  rd_fifo_fill_ctrl dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst),
    .frame_start(frame_start), .frame_base_addr(frame_base_addr), .frame_beats(frame_beats),
    .busy(busy), .frame_done(frame_done),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_full(fifo_wr_full), .fifo_water_level(fifo_water_level),
    .err(err)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int          errors;
  int          checks;
  int unsigned cyc;
  int          ready_mode;   // 0 always ready, 1 random, 2 ready_force
  logic        ready_force;
  int          drain_mode;   // 0 stalled, 1 random, 2 every cycle
  int          wl_override;  // negative: report model occupancy
  logic        force_full;
  logic        resp_hold;
  int unsigned fifo_cnt;

  int unsigned   resp_due[$];
  logic [DW-1:0] resp_data[$];
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [AW-1:0] got_addr[$];
  logic [7:0]    exp_len[$];
  logic [7:0]    got_len[$];
  int            accept_cnt, wr_cnt, done_cnt, data_bad, ovf_cnt, unexp_wr;
  int unsigned   last_wr_cyc, done_cyc;

  // One clock: drive environment inputs, observe the edge, update responder and FIFO models.
  task automatic step();
    logic          acc;
    logic          wr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [7:0]    l;
    case (ready_mode)
      0:       rd_cmd_ready = 1'b1;
      1:       rd_cmd_ready = 1'($urandom_range(0, 1));
      default: rd_cmd_ready = ready_force;
    endcase
    if (!resp_hold && resp_due.size() > 0 && resp_due[0] <= cyc + 1) begin
      rd_data_valid = 1'b1;
      rd_data       = resp_data.pop_front();
      void'(resp_due.pop_front());
      exp_data.push_back(rd_data);
    end else begin
      rd_data_valid = 1'b0;
    end
    fifo_water_level = (wl_override >= 0) ? 8'(wl_override) : 8'(fifo_cnt);
    fifo_wr_full     = force_full | (fifo_cnt >= CAP);
    acc  = rd_cmd_valid & rd_cmd_ready;
    a    = rd_cmd_addr;
    l    = rd_cmd_len;
    wr   = fifo_wr_en;
    wdat = fifo_wr_data;
    @(posedge wr_clk);
    #1;
    cyc++;
    if (acc) begin
      accept_cnt++;
      got_addr.push_back(a);
      got_len.push_back(l);
      for (int i = 0; i <= int'(l); i++) begin
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        resp_due.push_back(cyc + LAT);
        resp_data.push_back(d);
      end
    end
    if (wr === 1'b1) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (fifo_cnt >= CAP) ovf_cnt++;
      else fifo_cnt++;
      if (exp_data.size() == 0) unexp_wr++;
      else if (exp_data.pop_front() !== wdat) data_bad++;
    end
    if (fifo_cnt > 0 && (drain_mode == 2 || (drain_mode == 1 && $urandom_range(0, 1) == 1)))
      fifo_cnt--;
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_obs();
    resp_due.delete(); resp_data.delete(); exp_data.delete();
    exp_addr.delete(); got_addr.delete(); exp_len.delete(); got_len.delete();
    accept_cnt = 0; wr_cnt = 0; done_cnt = 0; data_bad = 0; ovf_cnt = 0; unexp_wr = 0;
    last_wr_cyc = 0; done_cyc = 0;
  endtask

  // Reference: split a frame into bursts of at most BL beats at consecutive beat addresses.
  task automatic plan_frame(input logic [AW-1:0] base, input int unsigned beats);
    logic [AW-1:0] a;
    int unsigned   rem;
    int unsigned   n;
    a   = base;
    rem = beats;
    while (rem > 0) begin
      n = (rem < BL) ? rem : BL;
      exp_addr.push_back(a);
      exp_len.push_back(8'(n - 1));
      a   = a + AW'(n * (DW / 8));
      rem = rem - n;
    end
  endtask

  function automatic int cmd_diff();
    int d;
    d = 0;
    if (exp_addr.size() != got_addr.size()) d++;
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      if (exp_addr[i] !== got_addr[i] || exp_len[i] !== got_len[i]) d++;
    return d;
  endfunction

  task automatic start_frame(input logic [AW-1:0] base, input int unsigned beats);
    frame_base_addr = base;
    frame_beats     = 24'(beats);
    frame_start     = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    timed_out = (done_cnt == 0);
    repeat (4) step();
  endtask

  task automatic test_reset();
    wr_rst = 1'b1;
    repeat (2) @(posedge wr_clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", frame_done); end
    checks++; if (rd_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", rd_cmd_valid); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%0b exp=0", fifo_wr_en); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++; if (rd_cmd_addr !== '0 || rd_cmd_len !== '0) begin errors++; $display("FAIL reset_cmd got=%0h/%0h exp=0/0", rd_cmd_addr, rd_cmd_len); end
    checks++; if (fifo_wr_data !== '0) begin errors++; $display("FAIL reset_data got=%0h exp=0", fifo_wr_data); end
    wr_rst = 1'b0;
    repeat (2) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_frame_64();
    bit to;
    clear_obs(); ready_mode = 0; drain_mode = 2;
    plan_frame(AW'(32'h100000), 64);
    start_frame(AW'(32'h100000), 64);
    wait_done(1500, to);
    checks++; if (to) begin errors++; $display("FAIL f64_timeout got=no_done exp=done"); end
    checks++; if (cmd_diff() !== 0) begin errors++; $display("FAIL f64_cmds got=%0d diffs exp=0", cmd_diff()); end
    checks++; if (got_addr.size() != 4 || got_addr[3] !== AW'(32'h100600)) begin errors++; $display("FAIL f64_last_addr got=%0h exp=100600", got_addr[got_addr.size()-1]); end
    checks++; if (wr_cnt !== 64) begin errors++; $display("FAIL f64_writes got=%0d exp=64", wr_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL f64_done_count got=%0d exp=1", done_cnt); end
    checks++; if (data_bad !== 0 || unexp_wr !== 0) begin errors++; $display("FAIL f64_data got=%0d/%0d exp=0/0", data_bad, unexp_wr); end
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL f64_end got=err%0b busy%0b exp=0/0", err, busy); end
  endtask

  task automatic test_frame_40();
    bit            to;
    logic [AW-1:0] base;
    clear_obs(); ready_mode = 1; drain_mode = 1;
    base = AW'($urandom) & ~AW'(31);
    plan_frame(base, 40);
    start_frame(base, 40);
    wait_done(1500, to);
    checks++; if (to) begin errors++; $display("FAIL f40_timeout got=no_done exp=done"); end
    checks++; if (cmd_diff() !== 0) begin errors++; $display("FAIL f40_cmds got=%0d diffs exp=0", cmd_diff()); end
    checks++; if (got_len.size() != 3 || got_len[2] !== 8'd7 || got_addr[2] !== base + AW'(32'h400)) begin errors++; $display("FAIL f40_last_cmd got=n%0d exp=n3 len7", got_len.size()); end
    checks++; if (wr_cnt !== 40) begin errors++; $display("FAIL f40_writes got=%0d exp=40", wr_cnt); end
    checks++; if (done_cnt !== 1 || !(done_cyc > last_wr_cyc)) begin errors++; $display("FAIL f40_done_order got=done%0d@%0d lastwr@%0d exp=1 after", done_cnt, done_cyc, last_wr_cyc); end
    checks++; if (data_bad !== 0 || unexp_wr !== 0) begin errors++; $display("FAIL f40_data got=%0d/%0d exp=0/0", data_bad, unexp_wr); end
  endtask

  task automatic test_water_level();
    bit to;
    int n;
    clear_obs(); ready_mode = 0; drain_mode = 0; wl_override = 111;
    plan_frame(AW'(32'h0200000), 16);
    start_frame(AW'(32'h0200000), 16);
    repeat (30) step();
    checks++; if (accept_cnt !== 0 || rd_cmd_valid !== 1'b0) begin errors++; $display("FAIL wl111_blocked got=acc%0d valid%0b exp=0/0", accept_cnt, rd_cmd_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wl111_busy got=%0b exp=1", busy); end
    wl_override = 110;
    n = 0;
    while (accept_cnt == 0 && n < 10) begin step(); n++; end
    checks++; if (accept_cnt !== 1) begin errors++; $display("FAIL wl110_issue got=%0d exp=1", accept_cnt); end
    wl_override = -1; drain_mode = 2;
    wait_done(500, to);
    checks++; if (to || cmd_diff() !== 0 || wr_cnt !== 16) begin errors++; $display("FAIL wl_finish got=to%0b diffs%0d wr%0d exp=0/0/16", to, cmd_diff(), wr_cnt); end
  endtask

  task automatic test_ready_stall();
    bit            to;
    int            n;
    logic [AW-1:0] base;
    clear_obs(); ready_mode = 2; ready_force = 1'b0; drain_mode = 2;
    base = AW'(32'h0ABC000);
    plan_frame(base, 32);
    start_frame(base, 32);
    n = 0;
    while (rd_cmd_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (rd_cmd_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_rise got=%0b exp=1", rd_cmd_valid); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (rd_cmd_valid !== 1'b1 || rd_cmd_addr !== base || rd_cmd_len !== 8'd15) begin errors++; $display("FAIL stall_hold_%0d got=%0b/%0h/%0h exp=1/%0h/f", i, rd_cmd_valid, rd_cmd_addr, rd_cmd_len, base); end
    end
    checks++; if (accept_cnt !== 0) begin errors++; $display("FAIL stall_no_accept got=%0d exp=0", accept_cnt); end
    ready_force = 1'b1;
    step();
    checks++; if (accept_cnt !== 1 || rd_cmd_valid !== 1'b0) begin errors++; $display("FAIL stall_accept got=acc%0d valid%0b exp=1/0", accept_cnt, rd_cmd_valid); end
    ready_mode = 0;
    wait_done(800, to);
    checks++; if (to || cmd_diff() !== 0 || wr_cnt !== 32) begin errors++; $display("FAIL stall_finish got=to%0b diffs%0d wr%0d exp=0/0/32", to, cmd_diff(), wr_cnt); end
  endtask

  task automatic test_start_while_busy();
    bit to;
    clear_obs(); ready_mode = 1; drain_mode = 1;
    plan_frame(AW'(32'h0300000), 48);
    start_frame(AW'(32'h0300000), 48);
    repeat (5) step();
    frame_base_addr = AW'(32'h0400000);
    frame_beats     = 24'd100;
    frame_start     = 1'b1;
    step();
    frame_start = 1'b0;
    wait_done(1500, to);
    checks++; if (to || cmd_diff() !== 0) begin errors++; $display("FAIL busy_start_cmds got=to%0b diffs%0d exp=0/0", to, cmd_diff()); end
    checks++; if (wr_cnt !== 48 || done_cnt !== 1 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_frame got=wr%0d done%0d busy%0b exp=48/1/0", wr_cnt, done_cnt, busy); end
  endtask

  task automatic test_overflow_and_zero();
    bit to;
    clear_obs(); ready_mode = 0; drain_mode = 0; force_full = 1'b1;
    plan_frame(AW'(32'h0500000), 16);
    start_frame(AW'(32'h0500000), 16);
    wait_done(500, to);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%0b exp=1", err); end
    checks++; if (to || wr_cnt !== 16) begin errors++; $display("FAIL ovf_writes_presented got=to%0b wr%0d exp=0/16", to, wr_cnt); end
    force_full = 1'b0; drain_mode = 2;
    clear_obs();
    start_frame(AW'(32'h0600000), 0);
    checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done got=done%0b busy%0b exp=1/0", frame_done, busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err_clear got=%0b exp=0", err); end
    step();
    checks++; if (frame_done !== 1'b0 || accept_cnt !== 0 || rd_cmd_valid !== 1'b0) begin errors++; $display("FAIL zero_pulse got=done%0b acc%0d exp=0/0", frame_done, accept_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    clear_obs(); ready_mode = 0; drain_mode = 2;
    start_frame(AW'(32'h0700000), 64);
    n = 0;
    while (accept_cnt == 0 && n < 20) begin step(); n++; end
    ready_mode = 2; ready_force = 1'b0;
    n = 0;
    while (wr_cnt < 8 && n < 40) begin step(); n++; end
    checks++; if (wr_cnt !== 8) begin errors++; $display("FAIL rst_pre_writes got=%0d exp=8", wr_cnt); end
    resp_hold = 1'b1;
    wr_rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rd_cmd_valid !== 1'b0 || fifo_wr_en !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_async_ctrl got=%0b%0b%0b%0b%0b exp=00000", busy, rd_cmd_valid, fifo_wr_en, frame_done, err); end
    checks++; if (rd_cmd_addr !== '0 || rd_cmd_len !== '0 || fifo_wr_data !== '0) begin errors++; $display("FAIL rst_async_data got=%0h/%0h exp=0/0", rd_cmd_addr, rd_cmd_len); end
    repeat (2) step();
    wr_rst = 1'b0; resp_hold = 1'b0;
    wr_cnt = 0;
    repeat (20) step();
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL rst_beats_dropped got=%0d exp=0", wr_cnt); end
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_unexpected_err got=err%0b busy%0b exp=1/0", err, busy); end
  endtask

  task automatic test_random();
    bit            to;
    int unsigned   beats;
    logic [AW-1:0] base;
    int unsigned   special [6];
    special = '{1, 16, 17, 128, 129, 40};
    for (int f = 0; f < 10; f++) begin
      clear_obs(); ready_mode = 1; drain_mode = 1;
      beats = (f < 6) ? special[f] : $urandom_range(2, 300);
      base  = (f == 5) ? AW'(32'hFFFFF00) : (AW'($urandom) & ~AW'(31));
      plan_frame(base, beats);
      start_frame(base, beats);
      wait_done(4000, to);
      checks++; if (to || cmd_diff() !== 0) begin errors++; $display("FAIL rnd%0d_cmds got=to%0b diffs%0d exp=0/0", f, to, cmd_diff()); end
      checks++; if (wr_cnt !== int'(beats) || done_cnt !== 1) begin errors++; $display("FAIL rnd%0d_frame got=wr%0d done%0d exp=%0d/1", f, wr_cnt, done_cnt, beats); end
      checks++; if (data_bad !== 0 || unexp_wr !== 0 || ovf_cnt !== 0 || err !== 1'b0) begin errors++; $display("FAIL rnd%0d_clean got=bad%0d unexp%0d ovf%0d err%0b exp=0", f, data_bad, unexp_wr, ovf_cnt, err); end
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    ready_mode = 0; ready_force = 1'b0; drain_mode = 2; wl_override = -1;
    force_full = 1'b0; resp_hold = 1'b0; fifo_cnt = 0;
    wr_rst = 1'b1; frame_start = 1'b0; frame_base_addr = '0; frame_beats = '0;
    rd_cmd_ready = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
    fifo_wr_full = 1'b0; fifo_water_level = '0;
    clear_obs();
    test_reset();
    test_frame_64();
    test_frame_40();
    test_water_level();
    test_ready_stall();
    test_start_while_busy();
    test_overflow_and_zero();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
